const_checker: RTL



---
 rtl/const_checker.sv | 110 +++++++++++
 1 files changed

// File: rtl/const_checker.sv
// const_checker: consumes an 8-entry constant stream over valid/ready and checks it
// against a fixed table, reporting pass/fail, mismatch count, first bad index and stall timeout.
module const_checker #(
    parameter int DATA_W  = 8,
    parameter int N_ITEMS = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [3:0]        err_cnt,
    output logic [2:0]        first_err_idx
);
    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    localparam logic [7:0][DATA_W-1:0] EXP = {8'hFB, 8'h59, 8'h05, 8'h5A, 8'h65, 8'h05, 8'h00, 8'h01};

    state_t      state, state_n;
    logic [2:0]  idx, idx_n, first_n;
    logic [7:0]  wait_cnt, wait_n;
    logic [3:0]  err_n;
    logic        ready_n, busy_n, done_n, pass_n, timeout_n;
    logic        xfer, mismatch, last;

    assign xfer     = in_valid && in_ready;
    assign mismatch = in_data != EXP[idx];
    assign last     = idx == 3'(N_ITEMS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            wait_cnt      <= '0;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            wait_cnt      <= wait_n;
            in_ready      <= ready_n;
            busy          <= busy_n;
            done          <= done_n;
            pass          <= pass_n;
            timeout       <= timeout_n;
            err_cnt       <= err_n;
            first_err_idx <= first_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        wait_n    = wait_cnt;
        ready_n   = in_ready;
        busy_n    = busy;
        done_n    = done;
        pass_n    = pass;
        timeout_n = timeout;
        err_n     = err_cnt;
        first_n   = first_err_idx;
        if (state != CHECK) begin
            if (start) begin
                state_n   = CHECK;
                idx_n     = '0;
                wait_n    = '0;
                ready_n   = 1'b1;
                busy_n    = 1'b1;
                done_n    = 1'b0;
                pass_n    = 1'b0;
                timeout_n = 1'b0;
                err_n     = '0;
                first_n   = '0;
            end
        end else if (xfer) begin
            err_n   = err_cnt + 4'(mismatch);
            first_n = (mismatch && err_cnt == 4'd0) ? idx : first_err_idx;
            idx_n   = idx + 3'd1;
            wait_n  = '0;
            if (last) begin
                state_n = DONE;
                ready_n = 1'b0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                pass_n  = err_cnt == 4'd0 && !mismatch;
            end
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            // stall abort keeps the error statistics gathered so far
            state_n   = DONE;
            ready_n   = 1'b0;
            busy_n    = 1'b0;
            done_n    = 1'b1;
            timeout_n = 1'b1;
            pass_n    = 1'b0;
        end else begin
            wait_n = wait_cnt + 8'd1;
        end
    end
endmodule
